// File: rtl/pong_game_controller.sv
// Pong game sequencer: one-hot game state, per-player scoring, serve pause timing
// and start/restart button handling. Every output is driven straight from a flop.
module pong_game_controller #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SERVE_DELAY = 25_000_000,
  parameter int unsigned TIMER_W     = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnC,
  input  logic       player_1_point,
  input  logic       player_2_point,
  output logic [3:0] state,
  output logic [3:0] player_1_score,
  output logic [3:0] player_2_score,
  output logic [1:0] winner
);

  typedef enum logic [3:0] {
    NEW_GAME  = 4'b0001,
    PLAY      = 4'b0010,
    NEW_BALL  = 4'b0100,
    GAME_OVER = 4'b1000
  } state_e;

  localparam logic [3:0]         WIN        = 4'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] SERVE_LAST = TIMER_W'(SERVE_DELAY - 1);

  state_e             state_q, state_d;
  logic [3:0]         p1_score_q, p1_score_d;
  logic [3:0]         p2_score_q, p2_score_d;
  logic [1:0]         winner_q, winner_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         sync_q, sync_d;
  logic               start;

  // sync_q[0]/[1] form the metastability synchroniser; sync_q[2] delays for edge detect.
  assign sync_d = {sync_q[1:0], btnC};
  assign start  = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d    = state_q;
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    winner_d   = winner_q;
    timer_d    = '0;
    case (state_q)
      NEW_GAME: begin
        p1_score_d = '0;
        p2_score_d = '0;
        winner_d   = '0;
        if (start) state_d = PLAY;
      end
      PLAY: begin
        if (player_1_point && !player_2_point) begin
          p1_score_d = p1_score_q + 4'd1;
          if (p1_score_d == WIN) begin
            state_d  = GAME_OVER;
            winner_d = 2'b01;
          end else begin
            state_d = NEW_BALL;
          end
        end else if (player_2_point && !player_1_point) begin
          p2_score_d = p2_score_q + 4'd1;
          if (p2_score_d == WIN) begin
            state_d  = GAME_OVER;
            winner_d = 2'b10;
          end else begin
            state_d = NEW_BALL;
          end
        end else if (player_1_point && player_2_point) begin
          state_d = NEW_BALL;
        end
      end
      NEW_BALL: begin
        if (timer_q == SERVE_LAST) state_d = PLAY;
        else                       timer_d = timer_q + 1'b1;
      end
      GAME_OVER: begin
        if (start) begin
          state_d    = NEW_GAME;
          p1_score_d = '0;
          p2_score_d = '0;
          winner_d   = '0;
        end
      end
      default: begin
        state_d    = NEW_GAME;
        p1_score_d = '0;
        p2_score_d = '0;
        winner_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= NEW_GAME;
      p1_score_q <= '0;
      p2_score_q <= '0;
      winner_q   <= '0;
      timer_q    <= '0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      p1_score_q <= p1_score_d;
      p2_score_q <= p2_score_d;
      winner_q   <= winner_d;
      timer_q    <= timer_d;
      sync_q     <= sync_d;
    end
  end

  assign state          = state_q;
  assign player_1_score = p1_score_q;
  assign player_2_score = p2_score_q;
  assign winner         = winner_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Directed bench for pong_game_controller (WIN_SCORE=3, SERVE_DELAY=4): expected
// output snapshots are queued with the edge count they apply to, a monitor checks them.
module tb_pong_game_controller;

  localparam logic [3:0] S_NG = 4'b0001;
  localparam logic [3:0] S_PL = 4'b0010;
  localparam logic [3:0] S_NB = 4'b0100;
  localparam logic [3:0] S_GO = 4'b1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btnC = 1'b0;
  logic       p1 = 1'b0;
  logic       p2 = 1'b0;
  logic [3:0] state;
  logic [3:0] s1, s2;
  logic [1:0] winner;

  pong_game_controller #(.WIN_SCORE(3), .SERVE_DELAY(4), .TIMER_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .btnC           (btnC),
    .player_1_point (p1),
    .player_2_point (p2),
    .state          (state),
    .player_1_score (s1),
    .player_2_score (s2),
    .winner         (winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    logic [3:0]  st;
    logic [3:0]  sc1;
    logic [3:0]  sc2;
    logic [1:0]  w;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (e.at != cyc) begin
        bad++;
        $display("FAIL %s: check for edge %0d reached late at edge %0d", e.nm, e.at, cyc);
      end else if (state !== e.st || s1 !== e.sc1 || s2 !== e.sc2 || winner !== e.w) begin
        bad++;
        $display("FAIL %s @%0d: got state=%b p1=%0d p2=%0d win=%b, want state=%b p1=%0d p2=%0d win=%b",
                 e.nm, cyc, state, s1, s2, winner, e.st, e.sc1, e.sc2, e.w);
      end
    end
  end

  function automatic void want(int unsigned at, logic [3:0] st, logic [3:0] a,
                               logic [3:0] b, logic [1:0] w, string nm);
    exp_t e;
    e.at = at; e.st = st; e.sc1 = a; e.sc2 = b; e.w = w; e.nm = nm;
    sb.push_back(e);
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle point pulse in PLAY, then wait out the 4-cycle serve.
  task automatic rally(input logic a, input logic b, input logic [3:0] e1,
                       input logic [3:0] e2, input string nm);
    int unsigned c;
    c = cyc;
    want(c + 1, S_NB, e1, e2, 2'b00, {nm, "_score"});
    want(c + 4, S_NB, e1, e2, 2'b00, {nm, "_serve_hold"});
    want(c + 5, S_PL, e1, e2, 2'b00, {nm, "_serve_done"});
    p1 = a; p2 = b;
    tick(1);
    p1 = 1'b0; p2 = 1'b0;
    tick(4);
  endtask

  task automatic press_start(input logic [3:0] st_before, input logic [3:0] st_after,
                             input logic [3:0] e1, input logic [3:0] e2,
                             input logic [1:0] w, input string nm);
    int unsigned c;
    c = cyc;
    want(c + 1, st_before, e1, e2, w, {nm, "_k"});
    want(c + 2, st_before, e1, e2, w, {nm, "_k1"});
    want(c + 3, st_after, 4'd0, (st_after == S_NG) ? 4'd0 : e2,
         (st_after == S_NG) ? 2'b00 : w, {nm, "_k2"});
    btnC = 1'b1;
    tick(1);
    btnC = 1'b0;
    tick(2);
  endtask

  initial begin
    int unsigned c;
    int unsigned guard;

    tick(2);
    reset = 1'b0;
    want(cyc + 20, S_NG, 4'd0, 4'd0, 2'b00, "reset_idle");
    tick(20);

    press_start(S_NG, S_PL, 4'd0, 4'd0, 2'b00, "start");

    // Held p1 flag: counted once only.
    c = cyc;
    want(c + 1, S_NB, 4'd1, 4'd0, 2'b00, "p1_hold_score");
    want(c + 3, S_NB, 4'd1, 4'd0, 2'b00, "p1_hold_no_double");
    want(c + 4, S_NB, 4'd1, 4'd0, 2'b00, "p1_hold_serve");
    want(c + 5, S_PL, 4'd1, 4'd0, 2'b00, "p1_hold_back");
    p1 = 1'b1;
    tick(3);
    p1 = 1'b0;
    tick(2);

    rally(1'b1, 1'b1, 4'd1, 4'd0, "both");
    rally(1'b0, 1'b1, 4'd1, 4'd1, "p2_a");
    rally(1'b0, 1'b1, 4'd1, 4'd2, "p2_b");

    c = cyc;
    want(c + 1, S_GO, 4'd1, 4'd3, 2'b10, "p2_win");
    want(c + 4, S_GO, 4'd1, 4'd3, 2'b10, "go_ignore_points");
    p2 = 1'b1;
    tick(1);
    p2 = 1'b0; p1 = 1'b1;
    tick(1);
    p1 = 1'b0; p2 = 1'b1;
    tick(1);
    p2 = 1'b0;
    tick(3);
    press_start(S_GO, S_NG, 4'd1, 4'd3, 2'b10, "restart");

    // Reset in NEW_BALL with timer=2 and score 1/2.
    press_start(S_NG, S_PL, 4'd0, 4'd0, 2'b00, "start2");
    rally(1'b1, 1'b0, 4'd1, 4'd0, "r_p1");
    rally(1'b0, 1'b1, 4'd1, 4'd1, "r_p2a");
    c = cyc;
    want(c + 1, S_NB, 4'd1, 4'd2, 2'b00, "r_p2b");
    want(c + 3, S_NB, 4'd1, 4'd2, 2'b00, "r_timer2");
    want(c + 4, S_NG, 4'd0, 4'd0, 2'b00, "mid_reset");
    p2 = 1'b1;
    tick(1);
    p2 = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    press_start(S_NG, S_PL, 4'd0, 4'd0, 2'b00, "start3");
    rally(1'b1, 1'b0, 4'd1, 4'd0, "post_reset");

    // Held button across PLAY entry and scoring.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    c = cyc;
    want(c + 3, S_PL, 4'd0, 4'd0, 2'b00, "hold_play");
    btnC = 1'b1;
    tick(4);
    rally(1'b1, 1'b0, 4'd1, 4'd0, "hold_r1");
    rally(1'b1, 1'b0, 4'd2, 4'd0, "hold_r2");
    c = cyc;
    want(c + 1, S_GO, 4'd3, 4'd0, 2'b01, "p1_win");
    want(c + 4, S_GO, 4'd3, 4'd0, 2'b01, "hold_go");
    p1 = 1'b1;
    tick(1);
    p1 = 1'b0;
    tick(3);
    c = cyc;
    want(c + 3, S_GO, 4'd3, 4'd0, 2'b01, "repress_k1");
    want(c + 4, S_NG, 4'd0, 4'd0, 2'b00, "repress_ng");
    want(c + 9, S_NG, 4'd0, 4'd0, 2'b00, "repress_single");
    btnC = 1'b0;
    tick(1);
    btnC = 1'b1;
    tick(8);
    btnC = 1'b0;

    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      tick(1);
      guard++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d checks pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_game_controller.md
# pong_game_controller

Game-level sequencer for the Pong datapath. It generates the one-hot `state` bus consumed by the paddle/ball position block, turns that block's `player_1_point` / `player_2_point` flags into per-player scores, and times the serve pause. It also detects the winning score and handles the start/restart button. It sits between the button inputs, the position block and the score display logic, on the single system clock.

## Interface
- `WIN_SCORE`, default 7: score that ends the game; legal range 1–15.
- `SERVE_DELAY`, default 25_000_000: number of `clk` cycles spent in NEW_BALL. Must be ≥ 2^19 in the full system so the position block's divided ball clock re-centres the ball.
- `TIMER_W`, default 26: serve timer width; 2^TIMER_W must be > SERVE_DELAY.

Ports:
- `clk`  in  1  system clock. All logic runs on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btnC`  in  1  start/restart button; asynchronous, raw level.
- `player_1_point`  in  1  level from the position block: ball passed the right edge.
- `player_2_point`  in  1  level from the position block: ball passed the left edge.
- `state`  out  4  one-hot game state: NEW_GAME=4'b0001, PLAY=4'b0010, NEW_BALL=4'b0100, GAME_OVER=4'b1000.
- `player_1_score`  out  4  player 1 score, unsigned.
- `player_2_score`  out  4  player 2 score, unsigned.
- `winner`  out  2  2'b00 none, 2'b01 player 1, 2'b10 player 2.

## Operation
- Every output is a register; there is no combinational path from input to output.
- Reset values: `state`=NEW_GAME, both scores 0, `winner`=0, serve timer 0, synchroniser flops 0.
- Button handling:
  - `btnC` passes through a 2-flop synchroniser (s1→s2), then a third flop s3.
  - `start` = s2 & ~s3, a one-cycle pulse per press.
- NEW_GAME:
  - Scores and `winner` are held at 0.
  - `start` → PLAY.
- PLAY:
  - p1 point only: `player_1_score` increments by 1. If the new value == WIN_SCORE, go to GAME_OVER with `winner`=01; otherwise go to NEW_BALL.
  - p2 point only: symmetric, with `winner`=10.
  - Both points in the same cycle: no score change; go to NEW_BALL (replay).
  - Neither point: stay in PLAY. `start` is ignored.
- NEW_BALL:
  - The timer is 0 on entry and increments every cycle.
  - When timer == SERVE_DELAY−1: go to PLAY and clear the timer. NEW_BALL therefore lasts exactly SERVE_DELAY cycles.
  - Point inputs and `start` are ignored. The position block clears its point flags while in NEW_BALL.
- GAME_OVER:
  - Scores and `winner` are held.
  - Point inputs are ignored.
  - `start` → NEW_GAME, and on that same edge both scores and `winner` clear to 0.
- Only one point is accepted per rally. PLAY is left on the same edge that scores, so point levels held high are never double-counted.
- Score arithmetic is 4-bit. A score never exceeds WIN_SCORE, so no wrap occurs.
- Illegal or non-one-hot `state` values recover to NEW_GAME on the next edge and clear scores.
- Reset asserted in any state returns to NEW_GAME with reset values on the next edge, overriding every other event.

## Timing
- Button latency: if `btnC` is first high at rising edge k, s2 rises at k+1 and `start` is high during cycle k+1. `state` changes at edge k+2.
- A held button produces exactly one `start` pulse. A new `start` needs `btnC` sampled low at least once.
- Point latency: a point flag high at edge k in PLAY gives the updated score and new `state` after edge k, both visible in the same cycle.
- NEW_BALL → PLAY: if NEW_BALL is entered at edge k, `state`=PLAY after edge k+SERVE_DELAY.
- GAME_OVER → NEW_GAME: scores and `winner` read 0 in the same cycle that `state` reads NEW_GAME.

## Test plan
Bench parameters: WIN_SCORE=3, SERVE_DELAY=4.
- Reset then idle 20 cycles → `state`=0001, scores 0/0, `winner`=00. Pulse `btnC` high at edge k → `state`=0010 after edge k+2, with no earlier change.
- In PLAY, hold `player_1_point` for 3 cycles → `player_1_score`=1 after the first edge only, `state`=0100. After exactly 4 more edges `state`=0010; `player_2_score` stays 0.
- Raise both point flags in the same PLAY cycle → scores unchanged, `state`=0100, then back to 0010 after 4 cycles.
- Score player 2 three times (driving flags low between rallies) → third point gives `player_2_score`=3, `state`=1000, `winner`=10. Further point pulses are ignored. Press `btnC` → `state`=0001, scores 0/0, `winner`=00 on the same edge.
- Assert `reset` for one cycle mid-NEW_BALL with timer=2 and score 1/2 → next edge `state`=0001 and all outputs at reset values. Press `btnC` → PLAY, and the first NEW_BALL after the next point again lasts a full 4 cycles.
- Hold `btnC` high across entry into PLAY, NEW_BALL and back → no extra transitions. Release for 1 cycle and press again in GAME_OVER → exactly one transition to NEW_GAME.
